// File: rtl/color_menu_nav_pkg.sv
// Shared definitions for the colour-menu navigation front end:
// menu item codes, FSM state encoding, button indices and selector helpers.
package color_menu_pkg;

    // Menu items, in cursor order; the last one leaves the menu.
    localparam logic [1:0] ITEM_RED   = 2'd0;
    localparam logic [1:0] ITEM_GREEN = 2'd1;
    localparam logic [1:0] ITEM_BLUE  = 2'd2;
    localparam logic [1:0] ITEM_EXIT  = 2'd3;

    // Navigation FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_NAV   = 2'd2
    } nav_state_t;

    // Bit positions of the buttons inside the packed button vectors.
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int NUM_BTNS   = 5;

    // Counter widths; both counters saturate instead of wrapping.
    localparam int DBNC_W = 16;
    localparam int RPT_W  = 24;

    // Cursor one step towards the top of the list, wrapping to the last item.
    function automatic logic [1:0] sel_prev(input logic [1:0] sel, input logic [1:0] last);
        return (sel == ITEM_RED) ? last : sel - 2'd1;
    endfunction

    // Cursor one step towards the bottom of the list, wrapping to the first item.
    function automatic logic [1:0] sel_next(input logic [1:0] sel, input logic [1:0] last);
        return (sel == last) ? ITEM_RED : sel + 2'd1;
    endfunction

endpackage

// File: rtl/color_menu_nav_debounce.sv
// One push-button path: 2-flop synchroniser, consecutive-cycle debounce
// counter and registered rising-edge detect of the debounced level.
module btn_debounce
    import color_menu_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000
) (
    input  logic slow_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DBNC_W-1:0] COUNT_LAST = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [DBNC_W-1:0] COUNT_MAX  = '1;

    logic              sync1_reg;
    logic              sync2_reg;
    logic              level_reg;
    logic              press_reg;
    logic [DBNC_W-1:0] count_reg;

    // Bring the asynchronous raw input into the clock domain.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Flip the debounced level after enough consecutive disagreeing cycles;
    // a single agreeing cycle restarts the count. Press marks a 0->1 flip.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (count_reg >= COUNT_LAST) begin
                    level_reg <= sync2_reg;
                    press_reg <= sync2_reg;
                    count_reg <= '0;
                end else if (count_reg != COUNT_MAX) begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/color_menu_nav.sv
// Colour-menu navigation front end: debounces five buttons, moves a
// wrap-around cursor over RED/GREEN/BLUE/EXIT and produces single-cycle
// left/right adjust pulses (with auto-repeat) and an exit request.
module color_menu_nav
    import color_menu_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd50000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd10000,
    parameter logic [2:0]  NUM_ITEMS       = 3'd4
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       menu_active,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [1:0] selector,
    output logic       left,
    output logic       right,
    output logic       exit_pulse,
    output logic       nav_busy
);

    localparam logic [2:0]       LAST_WIDE = NUM_ITEMS - 3'd1;
    localparam logic [1:0]       LAST_ITEM = LAST_WIDE[1:0];
    localparam logic [RPT_W-1:0] RPT_MAX   = '1;

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] level_btn;
    logic [NUM_BTNS-1:0] press_btn;

    nav_state_t       state_reg;
    logic [1:0]       selector_reg;
    logic             left_reg;
    logic             right_reg;
    logic             exit_reg;
    logic             nav_busy_reg;
    logic             rpt_active_reg;
    logic             rpt_first_reg;
    logic             rpt_dir_reg;     // 0 = left, 1 = right
    logic [RPT_W-1:0] rpt_cnt_reg;

    logic [1:0]       sel_target;
    logic             on_exit;
    logic             left_start;
    logic             right_start;
    logic             hold_match;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_due;

    assign raw_btn = {btn_center, btn_right, btn_left, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .slow_clock(slow_clock),
                .reset     (reset),
                .raw       (raw_btn[gi]),
                .level     (level_btn[gi]),
                .press     (press_btn[gi])
            );
        end
    endgenerate

    // Decode this cycle's button events into cursor and adjust intents.
    always_comb begin
        on_exit    = (selector_reg == LAST_ITEM);
        sel_target = selector_reg;
        if (press_btn[BTN_UP] && !press_btn[BTN_DOWN]) begin
            sel_target = sel_prev(selector_reg, LAST_ITEM);
        end else if (press_btn[BTN_DOWN] && !press_btn[BTN_UP]) begin
            sel_target = sel_next(selector_reg, LAST_ITEM);
        end
        // A new press only counts when the opposite direction is not held.
        left_start  = press_btn[BTN_LEFT]  && !level_btn[BTN_RIGHT] && !on_exit;
        right_start = press_btn[BTN_RIGHT] && !level_btn[BTN_LEFT]  && !on_exit;
        hold_match  = rpt_dir_reg ? (level_btn[BTN_RIGHT] && !level_btn[BTN_LEFT])
                                  : (level_btn[BTN_LEFT]  && !level_btn[BTN_RIGHT]);
        rpt_target  = rpt_first_reg ? REPEAT_DELAY : REPEAT_PERIOD;
        rpt_due     = (rpt_cnt_reg == rpt_target);
    end

    // Navigation FSM with registered cursor, pulses and auto-repeat timer.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            selector_reg   <= ITEM_RED;
            left_reg       <= 1'b0;
            right_reg      <= 1'b0;
            exit_reg       <= 1'b0;
            nav_busy_reg   <= 1'b0;
            rpt_active_reg <= 1'b0;
            rpt_first_reg  <= 1'b0;
            rpt_dir_reg    <= 1'b0;
            rpt_cnt_reg    <= '0;
        end else begin
            left_reg     <= 1'b0;
            right_reg    <= 1'b0;
            exit_reg     <= 1'b0;
            nav_busy_reg <= (state_reg == ST_NAV);
            if (!menu_active) begin
                // Menu closed from outside: drop back, keep the cursor.
                state_reg      <= ST_IDLE;
                rpt_active_reg <= 1'b0;
                rpt_cnt_reg    <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg      <= ST_ARMED;
                        selector_reg   <= ITEM_RED;
                        rpt_active_reg <= 1'b0;
                        rpt_cnt_reg    <= '0;
                    end
                    ST_ARMED: begin
                        // Do not start navigating until every button is released.
                        if (level_btn == '0) begin
                            state_reg <= ST_NAV;
                        end
                        rpt_active_reg <= 1'b0;
                        rpt_cnt_reg    <= '0;
                    end
                    ST_NAV: begin
                        if (press_btn[BTN_CENTER] && on_exit) begin
                            exit_reg       <= 1'b1;
                            state_reg      <= ST_IDLE;
                            rpt_active_reg <= 1'b0;
                            rpt_cnt_reg    <= '0;
                        end else begin
                            selector_reg <= sel_target;
                            if (left_start) begin
                                left_reg       <= 1'b1;
                                rpt_active_reg <= 1'b1;
                                rpt_first_reg  <= 1'b1;
                                rpt_dir_reg    <= 1'b0;
                                rpt_cnt_reg    <= 24'd1;
                            end else if (right_start) begin
                                right_reg      <= 1'b1;
                                rpt_active_reg <= 1'b1;
                                rpt_first_reg  <= 1'b1;
                                rpt_dir_reg    <= 1'b1;
                                rpt_cnt_reg    <= 24'd1;
                            end else if (rpt_active_reg && hold_match && !on_exit) begin
                                if (rpt_due) begin
                                    left_reg      <= !rpt_dir_reg;
                                    right_reg     <= rpt_dir_reg;
                                    rpt_first_reg <= 1'b0;
                                    rpt_cnt_reg   <= 24'd1;
                                end else if (rpt_cnt_reg != RPT_MAX) begin
                                    rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                                end
                            end else begin
                                rpt_active_reg <= 1'b0;
                                rpt_cnt_reg    <= '0;
                            end
                            // Moving the cursor always cancels any pending repeat.
                            if (sel_target != selector_reg) begin
                                rpt_active_reg <= 1'b0;
                                rpt_cnt_reg    <= '0;
                            end
                        end
                    end
                    default: begin
                        state_reg      <= ST_IDLE;
                        rpt_active_reg <= 1'b0;
                        rpt_cnt_reg    <= '0;
                    end
                endcase
            end
        end
    end

    assign selector   = selector_reg;
    assign left       = left_reg;
    assign right      = right_reg;
    assign exit_pulse = exit_reg;
    assign nav_busy   = nav_busy_reg;

endmodule
